dns_responder: RTL
==================

Name: dns_responder

Overview:
- Authoritative nameserver model: the responder end of the DNS lookup FSM's query path.
- Holds a small table of web-address to web-IP records, loaded through a record-write port.
- Answers one query at a time over a valid/ready handshake, returning the IP or a not-found flag plus the scan latency in cycles.
- Table search is sequential, one entry per cycle, to model lookup time.

Parameters:
DEPTH, 8, number of record slots (power of two, 2..16)
ADDR_W, 8, width of web address / query key
IP_W, 8, width of resolved IP

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
query_valid  in  1  query present
query_addr  in  ADDR_W  web address to resolve
query_ready  out  1  responder can accept a query this cycle
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response
resp_found  out  1  1 = record hit, 0 = not found
resp_ip  out  IP_W  resolved IP (0 on miss)
resp_latency  out  8  cycles from query accept to resp_valid
rec_wr_en  in  1  record write request
rec_wr_addr  in  ADDR_W  record key
rec_wr_ip  in  IP_W  record value
rec_wr_ready  out  1  write accepted this cycle when high with rec_wr_en
table_count  out  $clog2(DEPTH)+1  number of valid records
table_full  out  1  table_count == DEPTH

Behaviour:
- Reset (priority over everything, any state):
  - state = IDLE; all valid bits = 0; table_count = 0; victim pointer = 0.
  - resp_valid = 0, resp_found = 0, resp_ip = 0, resp_latency = 0.
  - An in-flight query is aborted with no response.
- FSM states IDLE, SCAN, RESPOND:
  - IDLE:
    - rec_wr_ready = 1.
    - query_ready = !rec_wr_en, so a write wins a simultaneous write+query and the query is accepted a later cycle.
    - On query_valid & query_ready: latch query_addr, scan index = 0, latency counter = 1, go to SCAN.
  - SCAN:
    - Each cycle, compare slot[index] (valid & key match).
    - Hit: resp_found = 1, resp_ip = slot IP, resp_latency = counter, go to RESPOND.
    - Miss at index DEPTH-1: resp_found = 0, resp_ip = 0, resp_latency = counter, go to RESPOND.
    - Otherwise: index++, counter++.
    - Counter saturates at 255.
  - RESPOND:
    - resp_valid = 1; resp_* held stable until resp_ready.
    - On resp_ready: resp_valid = 0 next cycle, go to IDLE.
    - No back-to-back acceptance in the handoff cycle.
  - query_ready = 0 and rec_wr_ready = 0 in SCAN and RESPOND; writes there are ignored (writer holds the request).
- Latency:
  - Hit in slot k gives resp_valid k+1 cycles after the accept edge, with resp_latency = k+1.
  - A miss gives DEPTH cycles, with resp_latency = DEPTH.
  - Duplicate keys cannot occur, so the lowest matching slot is the only match.
- Record write (IDLE only, one cycle, parallel compare):
  - Key already valid in some slot: overwrite its IP; table_count and victim pointer unchanged.
  - Else, not full: insert into the lowest-index invalid slot; table_count++.
  - Else, full: replace slot[victim]; victim = (victim+1) mod DEPTH; table_count unchanged.
  - A write is visible to the next accepted query.
- table_full is combinational from table_count.

Test Plan:
- Reset, then query 0x2A on the empty table -> resp_valid 8 cycles after accept; resp_found=0, resp_ip=0x00, resp_latency=8; table_count=0.
- Write 0x10->0xA1, 0x20->0xB2, 0x30->0xC3, then query 0x30 -> found=1, ip=0xC3, latency=3; table_count=3.
- Write 0x20->0xD4, then query 0x20 -> ip=0xD4, latency=2; table_count stays 3.
- Fill to 8 records (keys 0x10..0x80), write 0x99->0x55 -> slot0 replaced; query 0x10 -> miss, latency=8; query 0x99 -> hit, latency=1. Write 0xAA->0x66 -> slot1 (0x20) replaced.
- Hold resp_ready=0 for 5 cycles on a hit:
  - resp_valid and resp_* stay stable; query_ready=0 and rec_wr_ready=0 throughout.
  - Pulse rec_wr_en during the stall -> table unchanged.
  - Raise resp_ready -> IDLE next cycle.
- Drive rec_wr_en and query_valid together in IDLE -> write commits, query_ready=0 that cycle, query accepted next cycle and sees the new record.
- Assert rst mid-SCAN -> resp_valid never rises, table_count=0, and the next query misses.

Source files
------------

// File: rtl/dns_responder.sv
// dns_responder: authoritative nameserver model.
// A small table of address->IP records is loaded through a one-cycle write
// port and searched sequentially, one slot per cycle, when a query arrives.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The query port (query_valid/query_ready) and the record port
// (rec_wr_en/rec_wr_ready) are serviced only in IDLE, and a write wins over
// a simultaneous query. The response (resp_valid/resp_ready) is held stable
// from the edge resp_valid rises until the edge where resp_ready is seen.
module dns_responder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     query_valid,
  input  logic [ADDR_W-1:0]        query_addr,
  output logic                     query_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_found,
  output logic [IP_W-1:0]          resp_ip,
  output logic [7:0]               resp_latency,
  input  logic                     rec_wr_en,
  input  logic [ADDR_W-1:0]        rec_wr_addr,
  input  logic [IP_W-1:0]          rec_wr_ip,
  output logic                     rec_wr_ready,
  output logic [$clog2(DEPTH):0]   table_count,
  output logic                     table_full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // FSM state, visible hierarchically as dns_responder.state_q
  state_t              state_q, state_d;

  // Record table
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   key_q [DEPTH];
  logic [ADDR_W-1:0]   key_d [DEPTH];
  logic [IP_W-1:0]     ip_q  [DEPTH];
  logic [IP_W-1:0]     ip_d  [DEPTH];
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    victim_q, victim_d;

  // Scan context
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   qaddr_q, qaddr_d;
  logic [7:0]          lat_q, lat_d;

  // Registered response
  logic                resp_valid_q, resp_valid_d;
  logic                resp_found_q, resp_found_d;
  logic [IP_W-1:0]     resp_ip_q, resp_ip_d;
  logic [7:0]          resp_lat_q, resp_lat_d;

  // Write-side lookup results
  logic                wr_hit;
  logic [IDX_W-1:0]    wr_hit_idx;
  logic                wr_free;
  logic [IDX_W-1:0]    wr_free_idx;
  logic                wr_fire;
  logic                q_fire;
  logic                scan_hit;
  logic                tbl_full;

  assign query_ready  = (state_q == ST_IDLE) && !rec_wr_en;
  assign rec_wr_ready = (state_q == ST_IDLE);
  assign wr_fire      = rec_wr_en && rec_wr_ready;
  assign q_fire       = query_valid && query_ready;
  assign tbl_full     = (count_q == CNT_W'(DEPTH));
  assign scan_hit     = valid_q[idx_q] && (key_q[idx_q] == qaddr_q);

  assign resp_valid   = resp_valid_q;
  assign resp_found   = resp_found_q;
  assign resp_ip      = resp_ip_q;
  assign resp_latency = resp_lat_q;
  assign table_count  = count_q;
  assign table_full   = tbl_full;

  // Parallel key match and lowest free slot; descending loop lets the lowest index win
  always_comb begin
    wr_hit      = 1'b0;
    wr_hit_idx  = '0;
    wr_free     = 1'b0;
    wr_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == rec_wr_addr)) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        wr_free     = 1'b1;
        wr_free_idx = IDX_W'(i);
      end
    end
  end

  // Next-state logic for the FSM, the table and the response registers
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    key_d        = key_q;
    ip_d         = ip_q;
    count_d      = count_q;
    victim_d     = victim_q;
    idx_d        = idx_q;
    qaddr_d      = qaddr_q;
    lat_d        = lat_q;
    resp_valid_d = resp_valid_q;
    resp_found_d = resp_found_q;
    resp_ip_d    = resp_ip_q;
    resp_lat_d   = resp_lat_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_fire) begin
          if (wr_hit) begin
            ip_d[wr_hit_idx] = rec_wr_ip;
          end else if (wr_free) begin
            valid_d[wr_free_idx] = 1'b1;
            key_d[wr_free_idx]   = rec_wr_addr;
            ip_d[wr_free_idx]    = rec_wr_ip;
            count_d              = count_q + CNT_W'(1);
          end else begin
            key_d[victim_q] = rec_wr_addr;
            ip_d[victim_q]  = rec_wr_ip;
            victim_d        = victim_q + IDX_W'(1);
          end
        end
        if (q_fire) begin
          qaddr_d = query_addr;
          idx_d   = '0;
          lat_d   = 8'd1;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (scan_hit) begin
          resp_valid_d = 1'b1;
          resp_found_d = 1'b1;
          resp_ip_d    = ip_q[idx_q];
          resp_lat_d   = lat_q;
          state_d      = ST_RESPOND;
        end else if (idx_q == IDX_W'(DEPTH - 1)) begin
          resp_valid_d = 1'b1;
          resp_found_d = 1'b0;
          resp_ip_d    = '0;
          resp_lat_d   = lat_q;
          state_d      = ST_RESPOND;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (lat_q != 8'hFF) begin
            lat_d = lat_q + 8'd1;
          end
        end
      end

      ST_RESPOND: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears control, valid bits and the response
  always_ff @(posedge clk) begin
    key_q   <= key_d;
    ip_q    <= ip_d;
    idx_q   <= idx_d;
    qaddr_q <= qaddr_d;
    lat_q   <= lat_d;
    if (rst) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      count_q      <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_found_q <= 1'b0;
      resp_ip_q    <= '0;
      resp_lat_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      resp_found_q <= resp_found_d;
      resp_ip_q    <= resp_ip_d;
      resp_lat_q   <= resp_lat_d;
    end
  end

endmodule
